// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam int unsigned SEQDET_MIN_LEN = 2;

  // Width needed to hold a length value in the range 0..pat_w.
  function automatic int unsigned calc_len_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter; a clear beats an increment in the same cycle.
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial bit-pattern detector with saturating match count.
// Define SEQDET_MATCH_REG_EN to register the match output (one cycle later).
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter  int unsigned PAT_W = 8,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned LEN_W = calc_len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             din_valid,
  input  logic             din,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clr,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

  state_e           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_cfg_err;

  logic             w_cfg_acc;
  logic             w_len_ok;
  logic [PAT_W-1:0] w_window;
  logic [PAT_W-1:0] w_mask;
  logic             w_fill_ok;
  logic             w_eq;
  logic             w_match;

  assign cfg_ready = 1'b1;
  assign w_cfg_acc = cfg_valid && cfg_ready;
  assign w_len_ok  = (cfg_len >= LEN_W'(SEQDET_MIN_LEN)) && (cfg_len <= LEN_W'(PAT_W));

  // Newest bit sits at bit 0; only the low r_len bits take part in the compare.
  assign w_window  = {r_hist, din};
  assign w_mask    = ~({PAT_W{1'b1}} << r_len);
  assign w_fill_ok = ({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len};
  assign w_eq      = ((w_window ^ r_pat) & w_mask) == '0;
  assign w_match   = (r_state == RUN) && din_valid && !w_cfg_acc && w_fill_ok && w_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cfg_err <= 1'b0;
    end else if (w_cfg_acc) begin
      r_pat     <= cfg_pat;
      r_len     <= cfg_len;
      r_overlap <= cfg_overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= w_len_ok ? RUN : ERR;
      r_cfg_err <= !w_len_ok;
    end else if ((r_state == RUN) && din_valid) begin
      r_hist <= w_window[PAT_W-2:0];
      // Non-overlapping mode discards the bits that formed the match.
      if (w_match && !r_overlap) begin
        r_fill <= '0;
      end else if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

`ifdef SEQDET_MATCH_REG_EN
  logic r_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_match;
    end
  end

  assign match = r_match;
`else
  assign match = w_match;
`endif

  assign cfg_err = r_cfg_err;

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_match),
    .i_clr (cnt_clr),
    .o_cnt (match_cnt)
  );

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed, table-driven bench for seq_det_prog (PAT_W=8, CNT_W=2).
module tb_seq_det_prog;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             din_valid;
  logic             din;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_clr;
  logic             cfg_err;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_prev = 1'b0;

  typedef struct {
    logic dv;
    logic d;
    logic clr;
    logic m;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_det_prog #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pat     (cfg_pat),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din_valid   (din_valid),
    .din         (din),
    .match       (match),
    .match_cnt   (match_cnt),
    .cnt_clr     (cnt_clr),
    .cfg_err     (cfg_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // With a registered match output the observed value is the previous cycle's term.
  task automatic chk_match(input string nm, input logic term);
    logic want;
`ifdef SEQDET_MATCH_REG_EN
    want = exp_prev;
`else
    want = term;
`endif
    exp_prev = term;
    check(nm, 32'(match), 32'(want));
  endtask

  task automatic step(input logic cv, input logic dv, input logic d, input logic clr,
                      input logic m, input string nm);
    cfg_valid = cv;
    din_valid = dv;
    din       = d;
    cnt_clr   = clr;
    @(negedge clk);
    chk_match(nm, m);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                          input logic ov, input logic clr, input logic dv, input logic d);
    cfg_pat     = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    step(1'b1, dv, d, clr, 1'b0, "cfg_cycle_match");
  endtask

  function automatic void add(input logic dv, input logic d, input logic clr, input logic m);
    vec_t v;
    v.dv  = dv;
    v.d   = d;
    v.clr = clr;
    v.m   = m;
    tbl.push_back(v);
  endfunction

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].dv, tbl[i].d, tbl[i].clr, tbl[i].m, $sformatf("%s[%0d]", nm, i));
    end
    tbl.delete();
  endtask

  initial begin
    logic [7:0] ov_bits;
    logic [7:0] ov_exp;
    logic [7:0] no_exp;
    logic [7:0] p8;

    ov_bits = 8'b11011011;
    ov_exp  = 8'b00001001;
    no_exp  = 8'b00001000;
    p8      = 8'hA5;

    rst = 1'b1; cfg_valid = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;
    din_valid = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_match", 32'(match), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // IDLE ignores data entirely
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "idle_no_match");

    // Overlapping 11011
    load_cfg(8'b00011011, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ovl_cfg_err", 32'(cfg_err), 32'd0);
    for (int i = 7; i >= 0; i--) add(1'b1, ov_bits[i], 1'b0, ov_exp[i]);
    run_tbl("ovl");
    check("ovl_cnt", 32'(match_cnt), 32'd2);

    // Non-overlapping, counter cleared during the config cycle
    load_cfg(8'b00011011, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    check("novl_cnt_cleared", 32'(match_cnt), 32'd0);
    for (int i = 7; i >= 0; i--) add(1'b1, ov_bits[i], 1'b0, no_exp[i]);
    run_tbl("novl");
    check("novl_cnt", 32'(match_cnt), 32'd1);

    // Bubbles after every bit carry inverted junk on din
    load_cfg(8'b00011011, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      add(1'b1, ov_bits[i], 1'b0, ov_exp[i]);
      add(1'b0, ~ov_bits[i], 1'b0, 1'b0);
    end
    run_tbl("bub");
    check("bub_cnt", 32'(match_cnt), 32'd2);

    // Illegal length 1
    load_cfg(8'b00000001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ill1_cfg_err", 32'(cfg_err), 32'd1);
    for (int i = 0; i < 20; i++) add(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    run_tbl("ill1");
    check("ill1_cnt_held", 32'(match_cnt), 32'd2);

    // Illegal length PAT_W+1, then longest legal length PAT_W
    load_cfg(8'hFF, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ill9_cfg_err", 32'(cfg_err), 32'd1);
    load_cfg(p8, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    check("len8_cfg_err", 32'(cfg_err), 32'd0);
    for (int r = 0; r < 2; r++)
      for (int i = 7; i >= 0; i--) add(1'b1, p8[i], 1'b0, (i == 0));
    run_tbl("len8");
    check("len8_cnt", 32'(match_cnt), 32'd2);

    // Saturation: 11, six ones -> five matches, count pinned at 3
    load_cfg(8'b00000011, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b1, 1'b1, 1'b0, (i != 0));
    run_tbl("sat");
    check("sat_cnt", 32'(match_cnt), 32'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "clr_vs_inc_match");
    check("clr_vs_inc_cnt", 32'(match_cnt), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "post_clr_match");
    check("post_clr_cnt", 32'(match_cnt), 32'd1);

    // Config concurrent with a completing sample: config wins, sample dropped
    load_cfg(8'b00000011, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    check("cfgwin_cnt", 32'(match_cnt), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "cfgwin_first");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "cfgwin_second");
    check("cfgwin_cnt2", 32'(match_cnt), 32'd2);

    // Reset mid-pattern
    load_cfg(8'b00011011, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 7; i >= 4; i--) add(1'b1, ov_bits[i], 1'b0, 1'b0);
    run_tbl("pre_rst");
    rst = 1'b1;
    #2;
    check("midrst_match", 32'(match), 32'd0);
    check("midrst_cnt", 32'(match_cnt), 32'd0);
    check("midrst_cfg_err", 32'(cfg_err), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_prev = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) add(1'b1, 1'b1, 1'b0, 1'b0);
    run_tbl("after_rst");
    check("after_rst_cnt", 32'(match_cnt), 32'd0);
    load_cfg(8'b00000011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1);
    run_tbl("recfg");
    check("recfg_cnt", 32'(match_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Runtime-programmable serial bit-pattern detector that generalises the fixed-pattern Mealy detectors in the sequential-circuits library. Pattern length is parametrised up to PAT_W bits, and both pattern and length load at runtime through a valid/ready config port. Overlapping or non-overlapping detection is selectable, and a saturating match counter is provided. It sits directly on a 1-bit serial data stream with a qualifying strobe.

## Interface
Parameters:
- PAT_W, default 8: maximum pattern length in bits; legal range is 2 to 32.
- CNT_W, default 8: match counter width.
- LEN_W, derived, $clog2(PAT_W+1): width of the length field. Not user-set.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept; constant 1 (config is always accepted).
- cfg_pat  in  PAT_W  pattern; first-received bit at cfg_pat[cfg_len-1], last-received bit at cfg_pat[0]; upper bits ignored.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- din_valid  in  1  din qualifier.
- din  in  1  serial data bit.
- match  out  1  pattern-complete indication.
- match_cnt  out  CNT_W  saturating match count.
- cnt_clr  in  1  synchronous clear of match_cnt.
- cfg_err  out  1  last accepted config was illegal.

## Operation
- FSM states: IDLE, RUN, ERR. Reset state is IDLE.
- Config handshake: cfg_valid && cfg_ready latches pat, len and overlap, and clears hist and fill.
  - If 2 <= cfg_len <= PAT_W, next state is RUN and cfg_err = 0.
  - Otherwise, next state is ERR and cfg_err = 1.
  - Accept is legal from every state.
- IDLE and ERR: din is ignored and match = 0.
- RUN, on each din_valid:
  - hist shifts left by one with din entering at bit 0 (hist width is PAT_W-1).
  - fill increments, saturating at PAT_W-1.
- Mealy match term: RUN && din_valid && fill >= len-1 && {hist[len-2:0], din} == pat[len-1:0].
- On match:
  - overlap = 1: fill advances normally.
  - overlap = 0: fill is cleared to 0, so the bits just consumed cannot start a new match.
- din_valid = 0 cycles are bubbles: hist and fill hold, and partial progress is kept.
- Simultaneous config accept and din_valid: config wins, the din sample is discarded, and match = 0 that cycle.
- match_cnt increments on every match term and saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
  - A config load does not clear match_cnt.

## Timing
- Reset values: state IDLE, hist 0, fill 0, match 0, match_cnt 0, cfg_err 0, cfg_ready 1.
- Config accepted at edge N: detection uses the new pattern starting from the din sample at edge N+1.
- match latency: combinational, same cycle as the completing din sample (see Configuration).
- match_cnt is updated at the edge that samples the completing bit.
- rst mid-pattern discards all partial progress and the loaded config. The block returns to IDLE and needs a new config before it detects again.

## Configuration
- SEQDET_MATCH_REG_EN defined: match is a flop of the Mealy term, asserts one cycle after the completing sample, and resets to 0. match_cnt timing is unchanged.
- SEQDET_MATCH_REG_EN undefined: match is the combinational Mealy term.

## Structure
- Package seq_det_pkg holds:
  - the state enum (IDLE, RUN, ERR);
  - the constant SEQDET_MIN_LEN = 2;
  - a function computing LEN_W from PAT_W.
- Sub-module seq_det_sat_cnt: parametrised CNT_W saturating counter with inc and clr inputs, clr having priority.
- Top level contains the FSM, config registers, hist/fill logic and compare.

## Test plan
- Overlap: cfg pat=5'b11011, len=5, overlap=1; stream 1,1,0,1,1,0,1,1 -> match on bits 5 and 8; match_cnt=2.
- Non-overlap: same config with overlap=0, same stream -> match on bit 5 only; match_cnt=1.
- Bubbles: same stream as the overlap case with din_valid=0 inserted after every bit -> match on the same data bits; no match in bubble cycles.
- Illegal config: cfg_len=1, then 20 random bits -> cfg_err=1, state ERR, match never asserts. A following legal cfg clears cfg_err.
- Counter: CNT_W=2, pattern 2'b11, overlap=1, six 1s -> 5 matches and match_cnt stops at 3. cnt_clr asserted in the same cycle as a match -> match_cnt=0.
- Reset mid-pattern: rst after 4 bits of 11011 -> all outputs at reset values. Bit stream "1" afterwards produces no match until a new config is accepted.
